register_file: RTL and testbench

- 32-entry x 32-bit general-purpose register file for the processor datapath.
- Two combinational read ports (A1/RD1, A2/RD2) and one synchronous write port (A3/WD3/WE3).
- Sits between instruction decode (read-address sources) and writeback (write data and address).
- Register 0 is hardwired to zero, MIPS-style.

---
 rtl/register_file_if.sv | 15 +
 rtl/register_file.sv | 19 +
 tb/tb_register_file.sv | 118 +++++++++++
 3 files changed

// File: rtl/register_file_if.sv
// register_file_if: read/write port bundle between datapath (master) and register file (slave)
interface register_file_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0] A1;
  logic [ADDR_WIDTH-1:0] A2;
  logic [ADDR_WIDTH-1:0] A3;
  logic                  WE3;
  logic [DATA_WIDTH-1:0] WD3;
  logic [DATA_WIDTH-1:0] RD1;
  logic [DATA_WIDTH-1:0] RD2;
  modport master (output A1, A2, A3, WE3, WD3, input RD1, RD2);
  modport slave (input A1, A2, A3, WE3, WD3, output RD1, RD2);
endinterface

// File: rtl/register_file.sv
// register_file: 2-read/1-write register file with hardwired-zero entry 0 and async active-low reset
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input logic            clk,
  input logic            reset,
  register_file_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  logic [DATA_WIDTH-1:0] regs [DEPTH];
  always_ff @(posedge clk or negedge reset)
    if (!reset)
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    else if (bus.WE3 && bus.A3 != '0)
      regs[bus.A3] <= bus.WD3;
  assign bus.RD1 = bus.A1 == '0 ? '0 : regs[bus.A1];
  assign bus.RD2 = bus.A2 == '0 ? '0 : regs[bus.A2];
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed self-checking bench for register_file
module tb_register_file;
  logic clk;
  logic reset;
  int   checks;
  int   errors;
  register_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();
  register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    bus.WE3 = 1'b1;
    bus.A3 = 5'd15;
    bus.WD3 = 32'd31;
    bus.A1 = '0;
    bus.A2 = '0;
    repeat (10) @(posedge clk);
    #1;
    for (int i = 0; i < 32; i++) begin
      bus.A1 = 5'(i);
      bus.A2 = 5'(31 - i);
      #1;
      check($sformatf("rst_rd1[%0d]", i), bus.RD1, 32'd0);
      check($sformatf("rst_rd2[%0d]", 31 - i), bus.RD2, 32'd0);
    end
    @(negedge clk);
    reset = 1'b1;
    bus.A1 = 5'd15;
    #1;
    check("pre_release_write", bus.RD1, 32'd0);
    @(posedge clk);
    #1;
    check("first_write_reg15", bus.RD1, 32'd31);
    for (int i = 1; i <= 15; i++) begin
      bus.A1 = 5'(i);
      #2;
      check($sformatf("sweep_rd1[%0d]", i), bus.RD1, i == 15 ? 32'd31 : 32'd0);
    end
    @(negedge clk);
    bus.WD3 = 32'd255;
    bus.A3 = 5'd1;
    bus.WE3 = 1'b1;
    bus.A1 = 5'd15;
    bus.A2 = 5'd1;
    #1;
    check("rdw_before_edge", bus.RD2, 32'd0);
    @(posedge clk);
    #1;
    check("rdw_after_edge", bus.RD2, 32'd255);
    check("rdw_other_port", bus.RD1, 32'd31);
    @(negedge clk);
    bus.A3 = 5'd0;
    bus.WD3 = 32'hDEADBEEF;
    bus.A1 = 5'd0;
    bus.A2 = 5'd0;
    @(posedge clk);
    #1;
    check("zero_write_rd1", bus.RD1, 32'd0);
    check("zero_write_rd2", bus.RD2, 32'd0);
    @(negedge clk);
    bus.WE3 = 1'b0;
    bus.A3 = 5'd5;
    bus.WD3 = 32'd7;
    bus.A1 = 5'd5;
    @(posedge clk);
    #1;
    check("we_low_reg5", bus.RD1, 32'd0);
    @(negedge clk);
    bus.A1 = 5'd15;
    bus.A2 = 5'd1;
    #1;
    check("pre_reset_reg15", bus.RD1, 32'd31);
    check("pre_reset_reg1", bus.RD2, 32'd255);
    #1;
    reset = 1'b0;
    #1;
    check("async_reset_reg15", bus.RD1, 32'd0);
    check("async_reset_reg1", bus.RD2, 32'd0);
    for (int i = 0; i < 32; i++) begin
      bus.A1 = 5'(i);
      #1;
      check($sformatf("post_reset_sweep[%0d]", i), bus.RD1, 32'd0);
    end
    @(negedge clk);
    reset = 1'b1;
    bus.WE3 = 1'b1;
    for (int i = 1; i < 32; i++) begin
      bus.A3 = 5'(i);
      bus.WD3 = 32'(i * 3);
      @(negedge clk);
    end
    bus.WE3 = 1'b0;
    for (int i = 0; i < 32; i++) begin
      bus.A1 = 5'(i);
      bus.A2 = 5'(31 - i);
      #1;
      check($sformatf("pair_rd1[%0d]", i), bus.RD1, 32'(i * 3));
      check($sformatf("pair_rd2[%0d]", 31 - i), bus.RD2, 32'((31 - i) * 3));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
